// File: rtl/ct_packer_if.sv
// Byte-stream channel carrying packed ciphertext bytes from ct_packer to its sink.
// A byte transfers on a rising edge where valid and ready are both high; once valid is raised, data/last hold until that transfer.
interface ct_packer_if;
  logic       valid;
  logic [7:0] data;
  logic       last;
  logic       ready;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/ct_packer.sv
// ML-KEM-768 ciphertext serializer: reads compressed u[0..2] and v from the polynomial
// bank and bit-packs them (du=10, dv=4) into a 1088-byte stream, LSB-first.
module ct_packer #(
  parameter int SLOT_U0 = 16,
  parameter int SLOT_V  = 19,
  parameter int DU      = 10,
  parameter int DV      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic [4:0]  o_mem_slot,
  output logic [7:0]  o_mem_addr,
  input  logic [11:0] i_mem_din,
  ct_packer_if.master m_ct,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_CAPT = 3'd2,
    S_EMIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_poly, w_poly_nxt;
  logic [7:0]  r_coef, w_coef_nxt;
  logic        r_all_read, w_all_read_nxt;
  logic [4:0]  r_cnt, w_cnt_nxt;
  logic [23:0] r_acc, w_acc_nxt;
  logic [4:0]  r_mem_slot;
  logic [7:0]  r_mem_addr;

  logic        w_is_v;
  logic [4:0]  w_width;
  logic [23:0] w_coef_bits;
  logic        w_handshake;
  logic        w_unused_din;

  assign w_is_v       = (r_poly == 2'd3);
  assign w_width      = w_is_v ? 5'(DV) : 5'(DU);
  // Only the low width bits of the bank word belong to the compressed coefficient.
  assign w_coef_bits  = w_is_v ? 24'(i_mem_din[DV-1:0]) : 24'(i_mem_din[DU-1:0]);
  assign w_unused_din = ^i_mem_din[11:DU];
  assign w_handshake  = (r_state == S_EMIT) && m_ct.ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_poly_nxt     = r_poly;
    w_coef_nxt     = r_coef;
    w_all_read_nxt = r_all_read;
    w_cnt_nxt      = r_cnt;
    w_acc_nxt      = r_acc;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_state_nxt    = S_READ;
          w_poly_nxt     = 2'd0;
          w_coef_nxt     = 8'd0;
          w_all_read_nxt = 1'b0;
          w_cnt_nxt      = 5'd0;
          w_acc_nxt      = 24'd0;
        end else if (r_state == S_DONE) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_READ: w_state_nxt = S_CAPT;
      S_CAPT: begin
        w_acc_nxt  = r_acc | (w_coef_bits << r_cnt);
        w_cnt_nxt  = r_cnt + w_width;
        w_coef_nxt = r_coef + 8'd1;
        if (r_coef == 8'd255) begin
          w_poly_nxt = r_poly + 2'd1;
          if (w_is_v) w_all_read_nxt = 1'b1;
        end
        if (w_cnt_nxt >= 5'd8)   w_state_nxt = S_EMIT;
        else if (!w_all_read_nxt) w_state_nxt = S_READ;
        else                      w_state_nxt = S_DONE;
      end
      S_EMIT: begin
        if (w_handshake) begin
          w_acc_nxt = r_acc >> 8;
          w_cnt_nxt = r_cnt - 5'd8;
          if (w_cnt_nxt >= 5'd8) w_state_nxt = S_EMIT;
          else if (!r_all_read)  w_state_nxt = S_READ;
          else                   w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_poly     <= 2'd0;
      r_coef     <= 8'd0;
      r_all_read <= 1'b0;
      r_cnt      <= 5'd0;
      r_acc      <= 24'd0;
      r_mem_slot <= 5'd0;
      r_mem_addr <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_poly     <= w_poly_nxt;
      r_coef     <= w_coef_nxt;
      r_all_read <= w_all_read_nxt;
      r_cnt      <= w_cnt_nxt;
      r_acc      <= w_acc_nxt;
      // Address is loaded on entry to READ so the bank sees it during READ and answers in CAPT.
      if (w_state_nxt == S_READ) begin
        r_mem_slot <= (w_poly_nxt == 2'd3) ? 5'(SLOT_V) : 5'(SLOT_U0) + 5'(w_poly_nxt);
        r_mem_addr <= w_coef_nxt;
      end
    end
  end

  assign o_busy     = (r_state == S_READ) || (r_state == S_CAPT) || (r_state == S_EMIT);
  assign o_done     = (r_state == S_DONE);
  assign o_mem_slot = r_mem_slot;
  assign o_mem_addr = r_mem_addr;
  assign o_state    = r_state;

  assign m_ct.valid = (r_state == S_EMIT);
  assign m_ct.data  = r_acc[7:0];
  // Stream ends with exactly one byte pending once v is fully read.
  assign m_ct.last  = (r_state == S_EMIT) && r_all_read && (r_cnt == 5'd8);

endmodule

// File: tb/tb_ct_packer.sv
// Self-checking bench for ct_packer: bank model, directed runs, byte scoreboard with a
// decoupled monitor, backpressure, start-while-busy and mid-stream reset.
module tb_ct_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done;
  logic [4:0]  mem_slot;
  logic [7:0]  mem_addr;
  logic [11:0] mem_din;
  logic [2:0]  dbg_state;

  ct_packer_if ct_if ();

  ct_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (start),
    .o_busy     (busy),
    .o_done     (done),
    .o_mem_slot (mem_slot),
    .o_mem_addr (mem_addr),
    .i_mem_din  (mem_din),
    .m_ct       (ct_if.master),
    .o_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int mode = 0;
  logic [8:0] exp_q[$];
  int rx_count = 0;
  int done_cnt = 0;
  logic [7:0] got [1088];
  logic prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic prev_last;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (byte %0d)", name, act, req, rx_count);
    end
  endtask

  // ---------------- bank model (one-cycle read latency) ----------------
  function automatic logic [11:0] mem_val(input int m, input logic [4:0] s, input logic [7:0] a);
    logic [11:0] v;
    v = 12'h000;
    case (m)
      0: if (s >= 5'd16 && s <= 5'd18) v = {4'h0, a};
         else if (s == 5'd19) v = {8'h00, a[3:0]};
      1: if (s >= 5'd16 && s <= 5'd18) v = 12'h3FF;
         else if (s == 5'd19) v = 12'h00F;
      2: if (s >= 5'd16 && s <= 5'd19) v = 12'hFFF;
      3: if (s == 5'd16 && a == 8'd0) v = 12'h001;
         else if (s == 5'd16 && a == 8'd1) v = 12'h002;
      default: v = 12'h000;
    endcase
    return v;
  endfunction

  always @(posedge clk) mem_din <= mem_val(mode, mem_slot, mem_addr);

  // ---------------- expected stream ----------------
  task automatic push_expected(input int m);
    logic [7:0] byte_acc;
    logic [11:0] v;
    int nb, w, idx;
    exp_q.delete();
    if (m == 1 || m == 2) begin
      for (int i = 0; i < 1088; i++) exp_q.push_back({(i == 1087), 8'hFF});
    end else begin
      byte_acc = 8'h00;
      nb = 0;
      idx = 0;
      for (int p = 0; p < 4; p++) begin
        w = (p < 3) ? 10 : 4;
        for (int i = 0; i < 256; i++) begin
          v = mem_val(m, 5'(16 + p), 8'(i));
          for (int b = 0; b < w; b++) begin
            byte_acc[nb] = v[b];
            nb++;
            if (nb == 8) begin
              exp_q.push_back({(idx == 1087), byte_acc});
              idx++;
              nb = 0;
              byte_acc = 8'h00;
            end
          end
        end
      end
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", int'(ct_if.valid), 1);
        check("stall_data", int'(ct_if.data), int'(prev_data));
        check("stall_last", int'(ct_if.last), int'(prev_last));
      end
      if (done) begin
        done_cnt++;
        check("done_busy_low", int'(busy), 0);
      end
      if (ct_if.valid && ct_if.ready) begin
        check("byte_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("byte_data", int'(ct_if.data), int'(e[7:0]));
          check("byte_last", int'(ct_if.last), int'(e[8]));
        end
        if (rx_count < 1088) got[rx_count] = ct_if.data;
        rx_count++;
      end
      prev_stall = ct_if.valid && !ct_if.ready;
      prev_data  = ct_if.data;
      prev_last  = ct_if.last;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_valid"}, int'(ct_if.valid), 0);
    check({tag, "_data"}, int'(ct_if.data), 0);
    check({tag, "_last"}, int'(ct_if.last), 0);
    check({tag, "_slot"}, int'(mem_slot), 0);
    check({tag, "_addr"}, int'(mem_addr), 0);
  endtask

  task automatic run(input int m, input bit bp, input int poke_at, input int rst_at,
                     output int cyc, output int busy_c1, output int first_valid);
    int done0;
    bit poked, finished;
    mode = m;
    push_expected(m);
    rx_count = 0;
    done0 = done_cnt;
    poked = 1'b0;
    finished = 1'b0;
    first_valid = -1;
    busy_c1 = -1;
    @(posedge clk); #1;
    start = 1'b1;
    ct_if.ready = bp ? ($urandom_range(0, 99) < 40) : 1'b1;
    cyc = 0;
    for (int k = 0; k < 20000; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      ct_if.ready = bp ? ($urandom_range(0, 99) < 40) : 1'b1;
      if (cyc == 1) busy_c1 = int'(busy);
      if (ct_if.valid && first_valid < 0) first_valid = cyc;
      if (poke_at >= 0 && !poked && rx_count == poke_at) begin
        start = 1'b1;
        poked = 1'b1;
      end
      if (rst_at >= 0 && rx_count == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        ct_if.ready = 1'b1;
        return;
      end
      if (done) begin
        finished = 1'b1;
        break;
      end
    end
    check("done_seen", int'(finished), 1);
    @(negedge clk); #1;
    check("byte_count", rx_count, 1088);
    check("queue_drained", exp_q.size(), 0);
    check("done_pulses", done_cnt - done0, 1);
    @(posedge clk); #1;
    check("idle_after_done", int'(busy | done), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc, b1, fv;
    ct_if.ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Ramp, no backpressure: latency and cycle budget.
    run(0, 1'b0, -1, -1, cyc, b1, fv);
    check("busy_cycle1", b1, 1);
    check("first_valid_cycle", fv, 3);
    check("cycles_start_to_done", cyc + 1, 3138);
    check("ramp_byte0", int'(got[0]), 8'h00);
    check("ramp_byte1", int'(got[1]), 8'h04);
    check("ramp_byte960", int'(got[960]), 8'h10);

    // All-max and masked-upper-bits patterns.
    run(1, 1'b0, -1, -1, cyc, b1, fv);
    run(2, 1'b0, -1, -1, cyc, b1, fv);

    // Two low coefficients in u[0].
    run(3, 1'b0, -1, -1, cyc, b1, fv);
    check("mask_byte0", int'(got[0]), 8'h01);
    check("mask_byte1", int'(got[1]), 8'h08);

    // Backpressure plus a start pulse while busy.
    run(0, 1'b1, 500, -1, cyc, b1, fv);

    // Reset mid-stream, then a full fresh stream.
    run(0, 1'b1, -1, 700, cyc, b1, fv);
    @(posedge clk); #1;
    check_reset_outputs("post_reset");
    run(0, 1'b0, -1, -1, cyc, b1, fv);
    check("restart_byte1", int'(got[1]), 8'h04);
    check("restart_cycles", cyc + 1, 3138);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
